// File: rtl/vga_bounce_box.sv
// Pixel generator behind the VGA timing controller: draws a solid box on a background
// colour and moves it once per frame, bouncing off the edges of the active area.
module vga_bounce_box #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          H_START   = 145,
    parameter int          V_START   = 36,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          X0        = 0,
    parameter int          Y0        = 0,
    parameter logic [11:0] BOX_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h00F
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        run,
    input  logic        vActive,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [9:0]  hPixel,
    input  logic [9:0]  vLine,
    output logic [11:0] rgb,
    output logic        hSync_o,
    output logic        vSync_o,
    output logic        frame_tick,
    output logic        bounce,
    output logic [15:0] frame_cnt
);

    // state | meaning   (one direction FSM per axis)
    // INC   | position grows by STEP each tick until it reaches the far wall
    // DEC   | position shrinks by STEP each tick until it reaches zero
    typedef enum logic {INC, DEC} dir_t;

    localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);

    dir_t        dirX, dirY, nextDirX, nextDirY;
    logic [10:0] boxX, boxY, nextX, nextY;
    logic [10:0] pixX, pixY;
    logic        vsPrev, tick, hitX, hitY, inBox;

    assign tick = vSync & ~vsPrev;

    // Offsets wrap in 10 bits; only meaningful while vActive is high.
    assign pixX  = {1'b0, hPixel - 10'(H_START)};
    assign pixY  = {1'b0, vLine - 10'(V_START)};
    assign inBox = (pixX >= boxX) && (pixX < boxX + SIZE_W) &&
                   (pixY >= boxY) && (pixY < boxY + SIZE_W);

    always_comb begin
        nextX    = boxX;
        nextY    = boxY;
        nextDirX = dirX;
        nextDirY = dirY;
        hitX     = 1'b0;
        hitY     = 1'b0;
        if (tick && run) begin
            case (dirX)
                INC: if (boxX + STEP_W >= MAX_X) begin
                    nextX = MAX_X;  nextDirX = DEC;  hitX = 1'b1;
                end else begin
                    nextX = boxX + STEP_W;
                end
                DEC: if (boxX <= STEP_W) begin
                    nextX = 11'd0;  nextDirX = INC;  hitX = 1'b1;
                end else begin
                    nextX = boxX - STEP_W;
                end
                default: ;
            endcase
            case (dirY)
                INC: if (boxY + STEP_W >= MAX_Y) begin
                    nextY = MAX_Y;  nextDirY = DEC;  hitY = 1'b1;
                end else begin
                    nextY = boxY + STEP_W;
                end
                DEC: if (boxY <= STEP_W) begin
                    nextY = 11'd0;  nextDirY = INC;  hitY = 1'b1;
                end else begin
                    nextY = boxY - STEP_W;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rgb        <= 12'h000;
            hSync_o    <= 1'b1;
            vSync_o    <= 1'b0;
            frame_tick <= 1'b0;
            bounce     <= 1'b0;
            frame_cnt  <= 16'd0;
            vsPrev     <= 1'b0;
            boxX       <= 11'(X0);
            boxY       <= 11'(Y0);
            dirX       <= INC;
            dirY       <= INC;
        end else begin
            rgb        <= !vActive ? 12'h000 : (inBox ? BOX_COLOR : BG_COLOR);
            hSync_o    <= hSync;
            vSync_o    <= vSync;
            vsPrev     <= vSync;
            frame_tick <= tick;
            bounce     <= hitX | hitY;
            if (tick)
                frame_cnt <= frame_cnt + 16'd1;
            // Position only moves on a tick, so a visible frame never tears.
            boxX       <= nextX;
            boxY       <= nextY;
            dirX       <= nextDirX;
            dirY       <= nextDirY;
        end
    end

endmodule

// File: tb/tb_vga_bounce_box.sv
// Bench for vga_bounce_box: vector table, directed wall/corner/reset sequences and a
// randomized run, all checked against a frame-level position model.
module tb_vga_bounce_box;

    logic        clock = 1'b0;
    logic        rstN, run, vAct, hs, vs;
    logic [9:0]  hp, vl;
    logic [11:0] rgb0, rgb1;
    logic        hso0, hso1, vso0, vso1, ft0, ft1, bo0, bo1;
    logic [15:0] fc0, fc1;

    always #5 clock = ~clock;

    vga_bounce_box dut0 (
        .clock(clock), .rst_n(rstN), .run(run), .vActive(vAct), .hSync(hs), .vSync(vs),
        .hPixel(hp), .vLine(vl), .rgb(rgb0), .hSync_o(hso0), .vSync_o(vso0),
        .frame_tick(ft0), .bounce(bo0), .frame_cnt(fc0)
    );

    vga_bounce_box #(.X0(606), .Y0(446)) dut1 (
        .clock(clock), .rst_n(rstN), .run(run), .vActive(vAct), .hSync(hs), .vSync(vs),
        .hPixel(hp), .vLine(vl), .rgb(rgb1), .hSync_o(hso1), .vSync_o(vso1),
        .frame_tick(ft1), .bounce(bo1), .frame_cnt(fc1)
    );

    int nCmp = 0;
    int nBad = 0;

    // Reference model: box position as plain integers with a signed velocity.
    int          mX[2], mY[2], mVx[2], mVy[2];
    int          startX[2] = '{0, 606};
    int          startY[2] = '{0, 446};
    int          mCnt;
    logic        mPrev;
    logic        eTick, eHs, eVs;
    logic        eBounce[2];
    logic [11:0] eRgb[2];
    logic        lastFt, lastB0, lastB1, afterB1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic moveAxis(inout int pos, inout int vel, input int maxPos, inout logic hit);
        int np;
        np = pos + vel;
        if (np >= maxPos) begin
            np = maxPos; vel = -2; hit = 1'b1;
        end else if (np <= 0) begin
            np = 0; vel = 2; hit = 1'b1;
        end
        pos = np;
    endtask

    task automatic modelStep();
        int px, py;
        if (!rstN) begin
            for (int i = 0; i < 2; i++) begin
                mX[i] = startX[i]; mY[i] = startY[i]; mVx[i] = 2; mVy[i] = 2;
                eRgb[i] = 12'h000; eBounce[i] = 1'b0;
            end
            mPrev = 1'b0; mCnt = 0; eTick = 1'b0; eHs = 1'b1; eVs = 1'b0;
        end else begin
            px = (int'(hp) - 145) & 1023;
            py = (int'(vl) - 36) & 1023;
            for (int i = 0; i < 2; i++) begin
                if (!vAct)
                    eRgb[i] = 12'h000;
                else if (px >= mX[i] && px < mX[i] + 32 && py >= mY[i] && py < mY[i] + 32)
                    eRgb[i] = 12'hF00;
                else
                    eRgb[i] = 12'h00F;
                eBounce[i] = 1'b0;
            end
            eHs = hs; eVs = vs;
            eTick = vs && !mPrev;
            mPrev = vs;
            if (eTick) begin
                mCnt = (mCnt + 1) & 16'hFFFF;
                if (run)
                    for (int i = 0; i < 2; i++) begin
                        moveAxis(mX[i], mVx[i], 608, eBounce[i]);
                        moveAxis(mY[i], mVy[i], 448, eBounce[i]);
                    end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic rn, input logic va, input logic h,
                       input logic v, input logic [9:0] x, input logic [9:0] y);
        run = r; rstN = rn; vAct = va; hs = h; vs = v; hp = x; vl = y;
        @(posedge clock);
        #1;
        modelStep();
        chk("rgb0", 32'(rgb0), 32'(eRgb[0]));
        chk("rgb1", 32'(rgb1), 32'(eRgb[1]));
        chk("hsync0", 32'(hso0), 32'(eHs));
        chk("vsync0", 32'(vso0), 32'(eVs));
        chk("hsync1", 32'(hso1), 32'(eHs));
        chk("tick0", 32'(ft0), 32'(eTick));
        chk("tick1", 32'(ft1), 32'(eTick));
        chk("bounce0", 32'(bo0), 32'(eBounce[0]));
        chk("bounce1", 32'(bo1), 32'(eBounce[1]));
        chk("fcnt0", 32'(fc0), 32'(mCnt));
        chk("fcnt1", 32'(fc1), 32'(mCnt));
    endtask

    task automatic doReset();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd145, 10'd36);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd145, 10'd36);
    endtask

    task automatic tick(input logic r);
        cyc(r, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0);
        lastFt = ft0; lastB0 = bo0; lastB1 = bo1;
        cyc(r, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
        afterB1 = bo1;
    endtask

    task automatic probe(input int inst, input int x, input int y, input logic [11:0] exp,
                         input string nm);
        cyc(run, 1'b1, 1'b1, 1'b1, 1'b0, 10'(x + 145), 10'(y + 36));
        chk(nm, 32'(inst == 0 ? rgb0 : rgb1), 32'(exp));
    endtask

    typedef struct {
        logic        va;
        logic        h;
        logic        v;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] expRgb;
        logic        expHs;
        logic        expVs;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int x, y, k;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 10'd145, 10'd36, 12'hF00, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 10'd177, 10'd36, 12'h00F, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 10'd176, 10'd36, 12'hF00, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 10'd145, 10'd68, 12'h00F, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 10'd176, 10'd67, 12'hF00, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 10'd145, 10'd36, 12'h000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 10'd144, 10'd36, 12'h00F, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 10'd160, 10'd50, 12'hF00, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 10'd160, 10'd50, 12'hF00, 1'b1, 1'b0};

        // Reset values
        doReset();
        chk("rst_rgb", 32'(rgb0), 32'h000);
        chk("rst_hsync", 32'(hso0), 32'h1);
        chk("rst_vsync", 32'(vso0), 32'h0);
        chk("rst_fcnt", 32'(fc0), 32'h0);

        // Pixel map with the box frozen at (0,0)
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b1, vecs[i].va, vecs[i].h, vecs[i].v, vecs[i].x, vecs[i].y);
            chk($sformatf("vec%0d_rgb", i), 32'(rgb0), 32'(vecs[i].expRgb));
            chk($sformatf("vec%0d_hs", i), 32'(hso0), 32'(vecs[i].expHs));
            chk($sformatf("vec%0d_vs", i), 32'(vso0), 32'(vecs[i].expVs));
        end

        // Three moving frames
        doReset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            chk("mot_tick", 32'(lastFt), 32'h1);
            chk("mot_bounce", 32'(lastB0), 32'h0);
        end
        chk("mot_fcnt", 32'(fc0), 32'd3);
        probe(0, 6, 6, 12'hF00, "mot_in");
        probe(0, 5, 6, 12'h00F, "mot_left");
        probe(0, 6, 5, 12'h00F, "mot_top");
        probe(0, 37, 37, 12'hF00, "mot_br");
        probe(0, 38, 6, 12'h00F, "mot_right");

        // Right wall: box reaches x=604 after 302 frames
        doReset();
        for (int i = 0; i < 302; i++) tick(1'b1);
        tick(1'b1);
        chk("xw1_bounce", 32'(lastB0), 32'h0);
        probe(0, 606, mY[0], 12'hF00, "xw1_in");
        probe(0, 605, mY[0], 12'h00F, "xw1_out");
        tick(1'b1);
        chk("xw2_bounce", 32'(lastB0), 32'h1);
        probe(0, 608, mY[0], 12'hF00, "xw2_in");
        probe(0, 607, mY[0], 12'h00F, "xw2_out");
        tick(1'b1);
        chk("xw3_bounce", 32'(lastB0), 32'h0);
        probe(0, 606, mY[0], 12'hF00, "xw3_in");
        probe(0, 605, mY[0], 12'h00F, "xw3_out");

        // Corner hit on the instance starting at (606,446)
        doReset();
        tick(1'b1);
        chk("cor_bounce", 32'(lastB1), 32'h1);
        chk("cor_tick", 32'(lastFt), 32'h1);
        chk("cor_pulse_end", 32'(afterB1), 32'h0);
        probe(1, 608, 448, 12'hF00, "cor_in");
        probe(1, 607, 448, 12'h00F, "cor_left");
        probe(1, 608, 447, 12'h00F, "cor_top");
        tick(1'b1);
        chk("cor2_bounce", 32'(lastB1), 32'h0);
        probe(1, 606, 446, 12'hF00, "cor2_in");
        probe(1, 605, 446, 12'h00F, "cor2_left");

        // Mid-frame reset, then frozen motion
        doReset();
        for (int i = 0; i < 20; i++) tick(1'b1);
        probe(0, 40, 40, 12'hF00, "mid_in");
        probe(0, 39, 40, 12'h00F, "mid_left");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd185, 10'd76);
        probe(0, 0, 0, 12'hF00, "mrst_origin");
        probe(0, 40, 40, 12'h00F, "mrst_old");
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            chk("frz_tick", 32'(lastFt), 32'h1);
            chk("frz_bounce", 32'(lastB0), 32'h0);
        end
        chk("frz_fcnt", 32'(fc0), 32'd5);
        probe(0, 0, 0, 12'hF00, "frz_in");
        probe(0, 32, 0, 12'h00F, "frz_out");

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 1);
                x = mX[k] + int'($urandom_range(0, 40)) - 4;
                y = mY[k] + int'($urandom_range(0, 40)) - 4;
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 299) != 0,
                $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0 ? ~vs : vs,
                10'(x + 145), 10'(y + 36));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
